// File: rtl/regfile_mp_pkg.sv
// Shared limits and defaults for the multi-port register file.
`include "defines.v"

package regfile_mp_pkg;
  localparam int RF_XLEN          = `XLEN;
  localparam int RF_IDX_W         = `RFIDX_WIDTH;
  localparam int RF_NR_READ_MAX   = `RF_NR_READ_MAX;
  localparam int RF_NR_WRITE_MAX  = `RF_NR_WRITE_MAX;

  function automatic bit rf_params_ok(input int nr_read, input int nr_write);
    return (nr_read >= 1) && (nr_read <= RF_NR_READ_MAX) &&
           (nr_write >= 1) && (nr_write <= RF_NR_WRITE_MAX);
  endfunction
endpackage

// File: rtl/defines.v
// Global core widths and register-file port limits.
`ifndef REGFILE_DEFINES_V
`define REGFILE_DEFINES_V
`define XLEN            32
`define RFIDX_WIDTH     5
`define RF_NR_READ_MAX  4
`define RF_NR_WRITE_MAX 2
`endif

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard; lookups return the post-edge (next-state) busy bit.
// Alloc beats same-cycle write-clear, x0 is never busy.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int RFIDX_WIDTH = RF_IDX_W,
  parameter int NR_READ     = 2,
  parameter int NR_WRITE    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_en,
  input  logic [RFIDX_WIDTH-1:0]          alloc_addr,
  input  logic [NR_WRITE*RFIDX_WIDTH-1:0] write_addr,
  input  logic [NR_WRITE-1:0]             reg_write,
  input  logic [NR_READ*RFIDX_WIDTH-1:0]  lookup_addr,
  output logic [NR_READ-1:0]              lookup_busy
);
  localparam int DEPTH = 2 ** RFIDX_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    for (int j = 0; j < NR_WRITE; j++) begin
      if (reg_write[j]) w_busy_next[write_addr[j*RFIDX_WIDTH +: RFIDX_WIDTH]] = 1'b0;
    end
    // New producer outranks a retiring one on the same register.
    if (alloc_en) w_busy_next[alloc_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  always_comb begin
    lookup_busy = '0;
    for (int i = 0; i < NR_READ; i++) begin
      lookup_busy[i] = w_busy_next[lookup_addr[i*RFIDX_WIDTH +: RFIDX_WIDTH]];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: x0 hardwired zero, 1-cycle registered reads with
// write bypass, and an integrated busy scoreboard for issue.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN        = RF_XLEN,
  parameter int RFIDX_WIDTH = RF_IDX_W,
  parameter int NR_READ     = 2,
  parameter int NR_WRITE    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NR_READ*RFIDX_WIDTH-1:0]  read_addr,
  input  logic [NR_READ-1:0]              read_en,
  output logic [NR_READ*XLEN-1:0]         read_data,
  output logic [NR_READ-1:0]              read_busy,
  input  logic [NR_WRITE*RFIDX_WIDTH-1:0] write_addr,
  input  logic [NR_WRITE*XLEN-1:0]        write_data,
  input  logic [NR_WRITE-1:0]             reg_write,
  input  logic                            alloc_en,
  input  logic [RFIDX_WIDTH-1:0]          alloc_addr
);
  localparam int DEPTH = 2 ** RFIDX_WIDTH;

  if (!rf_params_ok(NR_READ, NR_WRITE)) begin : g_param_check
    $error("regfile_mp: NR_READ must be 1..%0d and NR_WRITE 1..%0d",
           RF_NR_READ_MAX, RF_NR_WRITE_MAX);
  end

  logic [XLEN-1:0]         r_mem [DEPTH];
  logic [NR_READ*XLEN-1:0] r_read_data;
  logic [NR_READ-1:0]      r_read_busy;
  logic [NR_READ*XLEN-1:0] w_rd_val;
  logic [NR_READ-1:0]      w_busy_lookup;

  regfile_scoreboard #(
    .RFIDX_WIDTH (RFIDX_WIDTH),
    .NR_READ     (NR_READ),
    .NR_WRITE    (NR_WRITE)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .write_addr  (write_addr),
    .reg_write   (reg_write),
    .lookup_addr (read_addr),
    .lookup_busy (w_busy_lookup)
  );

  // Later (higher-index) write port overrides earlier ones in both store and bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NR_WRITE; j++) begin
        if (reg_write[j] && (write_addr[j*RFIDX_WIDTH +: RFIDX_WIDTH] != '0))
          r_mem[write_addr[j*RFIDX_WIDTH +: RFIDX_WIDTH]] <= write_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NR_READ; i++) begin
      if (read_addr[i*RFIDX_WIDTH +: RFIDX_WIDTH] != '0) begin
        w_rd_val[i*XLEN +: XLEN] = r_mem[read_addr[i*RFIDX_WIDTH +: RFIDX_WIDTH]];
        for (int j = 0; j < NR_WRITE; j++) begin
          if (reg_write[j] &&
              (write_addr[j*RFIDX_WIDTH +: RFIDX_WIDTH] == read_addr[i*RFIDX_WIDTH +: RFIDX_WIDTH]))
            w_rd_val[i*XLEN +: XLEN] = write_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_data <= '0;
      r_read_busy <= '0;
    end else begin
      for (int i = 0; i < NR_READ; i++) begin
        if (read_en[i]) begin
          r_read_data[i*XLEN +: XLEN] <= w_rd_val[i*XLEN +: XLEN];
          r_read_busy[i]              <= w_busy_lookup[i];
        end
      end
    end
  end

  assign read_data = r_read_data;
  assign read_busy = r_read_busy;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation core: `NR_READ` read ports and `NR_WRITE` write ports.
- Architectural x0 is hardwired to zero.
- Reads are synchronous on the rising edge, with write-to-read bypass.
- An integrated per-register busy scoreboard lets issue logic detect pending producers.
- Sits between decode/issue (read/alloc side) and writeback (write side).

Parameters:
- `XLEN`, default `` `XLEN `` (32): data width per register.
- `RFIDX_WIDTH`, default `` `RFIDX_WIDTH `` (5): address width; depth = 2**`RFIDX_WIDTH`.
- `NR_READ`, default 2: number of read ports, range 1..4.
- `NR_WRITE`, default 1: number of write ports, range 1..2.

Ports:
- `clk`  in  1  — single clock, all logic on posedge.
- `rst`  in  1  — synchronous active-high reset.
- `read_addr`  in  `NR_READ`*`RFIDX_WIDTH`  — packed read addresses; port i at slice [i*`RFIDX_WIDTH` +: `RFIDX_WIDTH`].
- `read_en`  in  `NR_READ`  — per-port read enable.
- `read_data`  out  `NR_READ`*`XLEN`  — registered read data, packed like `read_addr`.
- `read_busy`  out  `NR_READ`  — registered busy flag of each addressed register.
- `write_addr`  in  `NR_WRITE`*`RFIDX_WIDTH`  — packed write addresses.
- `write_data`  in  `NR_WRITE`*`XLEN`  — packed write data.
- `reg_write`  in  `NR_WRITE`  — per-port write enable.
- `alloc_en`  in  1  — mark `alloc_addr` busy (destination issued).
- `alloc_addr`  in  `RFIDX_WIDTH`  — register to mark busy.

Behaviour:
- Reset (`rst`=1 at posedge):
  - All registers cleared to 0.
  - All busy bits cleared.
  - `read_data` = 0 and `read_busy` = 0.
  - Writes and allocs presented in the same cycle are ignored.
  - Reset overrides everything, mid-operation included.
- Write: at posedge, if `reg_write`[j]=1 and `write_addr`[j]≠0, the register takes `write_data`[j]. Writes to x0 are discarded.
- Write conflict: if two write ports target the same non-zero address in one cycle, the higher port index wins.
- Read latency is 1 cycle. At posedge with `read_en`[i]=1, `read_data`[i] is loaded and valid from that edge until the next enabled read. With `read_en`[i]=0, `read_data`[i] and `read_busy`[i] hold.
- Read value:
  - `read_addr`[i]=0 gives 0.
  - Otherwise, if any write port targets the same address in the same cycle, the bypassed `write_data` is returned (highest matching index).
  - Otherwise the stored value.
- Scoreboard, one busy bit per register; x0 is never busy:
  - Set at posedge when `alloc_en`=1 and `alloc_addr`≠0.
  - Cleared at posedge when any `reg_write`[j]=1 with `write_addr`[j] equal to that register.
  - Same register allocated and written in the same cycle: busy ends at 1 (the new producer wins); the data write still occurs.
- `read_busy`[i] reflects the busy state after the same edge's updates:
  - Write to the address in the same cycle and no alloc gives 0.
  - Alloc to the address in the same cycle gives 1.
  - x0 gives 0.
- No combinational path from inputs to outputs; all outputs are flops.
- Width: addresses are unsigned, with no wrap or truncation. Out-of-range parameter values are illegal and must be flagged with an elaboration-time check.

Decomposition:
- `` `XLEN `` and `` `RFIDX_WIDTH `` stay in `defines.v`.
- Add `` `RF_NR_READ_MAX `` (4) and `` `RF_NR_WRITE_MAX `` (2) there.
- One sub-module, `regfile_scoreboard`:
  - Ports: `clk`, `rst`, `alloc_en`, `alloc_addr`, the write vectors, and the `NR_READ` lookup addresses.
  - Output: next-state busy lookups.
  - Holds the busy vector and its set/clear priority.
- The data array, bypass mux and output registers remain in `regfile_mp`.

Test Plan:
- Reset then read:
  - Stimulus: assert `rst` 1 cycle; then read x5 and x31 on ports 0/1.
  - Response: `read_data`=0 and `read_busy`=0 on the next cycle.
  - Stimulus: write x3=0xDEADBEEF, then deassert `reg_write`; next cycle read x3.
  - Response: 0xDEADBEEF one cycle after `read_en`.
- x0 protection: write x0=0xFFFFFFFF -> a later read of x0 returns 0, and `alloc_addr`=0 never sets busy.
- Bypass and conflict (`NR_WRITE`=2):
  - Stimulus: same cycle, port0 writes x7=0x11, port1 writes x7=0x22, and port0 reads x7.
  - Response: `read_data`=0x22; a subsequent read also gives 0x22.
- Scoreboard:
  - Stimulus: alloc x9, then read x9.
  - Response: `read_busy`=1.
  - Stimulus: write x9=0x55.
  - Response: same-cycle read gives busy 0 and data 0x55.
  - Stimulus: alloc and write x9 in the same cycle.
  - Response: busy stays 1.
- Reset mid-operation:
  - Stimulus: x4 holds 0xA5, x4 is busy, then `rst` is asserted in the same cycle as a write x4=0x77 and an alloc of x6.
  - Response: next reads give x4=0, x6 not busy, all outputs 0.
